stream_downsizer: RTL and testbench

- Valid/ready stream width converter: accepts one wide word per input handshake and emits it as RATIO narrow beats on the output stream.
- Sits between a wide producer (e.g. a bus data path) and a narrow consumer (e.g. a byte-serial peripheral).
- Holds exactly one wide word. Sustains full output throughput (one narrow beat per cycle) by accepting the next wide word in the same cycle the last narrow beat handshakes.
- Supports a synchronous flush.

---
 rtl/stream_downsizer_if.sv | 13 +
 rtl/stream_downsizer.sv | 90 +++++++++
 tb/tb_stream_downsizer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_downsizer_if.sv
// Valid/ready stream bundle with an optional end-of-word marker.
// The producer drives valid/data/last, the consumer drives ready.
interface stream_downsizer_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic             last;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: holds one wide word and emits it as RATIO
// narrow beats. The next word is accepted in the cycle the last beat leaves,
// so the narrow side can run at one beat per cycle without bubbles.
module stream_downsizer #(
  parameter int DATA_WIDTH_IN = 32,
  parameter int RATIO         = 4,
  parameter bit LSB_FIRST     = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  stream_downsizer_if.slave      in_if,
  stream_downsizer_if.master     out_if
);

  localparam int DATA_WIDTH_OUT = DATA_WIDTH_IN / RATIO;
  localparam int CNT_WIDTH      = $clog2(RATIO);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

  generate
    if (RATIO < 2 || (DATA_WIDTH_IN % RATIO) != 0) begin : g_bad_cfg
      $fatal(1, "stream_downsizer: RATIO must be >= 2 and divide DATA_WIDTH_IN");
    end
  endgenerate

  logic [DATA_WIDTH_IN-1:0]  data_q, data_d;
  logic                      full_q, full_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]      slice_idx;
  logic [DATA_WIDTH_OUT-1:0] beat;
  logic                      last;
  logic                      in_hs;
  logic                      out_hs;

  assign last   = full_q && (cnt_q == CNT_LAST);
  // Only the last beat lets ready_i reach ready_o; that is what removes the bubble.
  assign in_if.ready = !flush_i && (!full_q || (out_if.ready && last));
  assign in_hs  = in_if.valid && in_if.ready;
  assign out_hs = full_q && out_if.ready;

  assign slice_idx = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);

  // Select the current narrow slice from the held word (registers only).
  always_comb begin
    beat = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (slice_idx == CNT_WIDTH'(k)) begin
        beat = data_q[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
      end
    end
  end

  // Next-state: flush beats a new word, a new word beats beat advance.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      full_d = 1'b0;
      cnt_d  = '0;
    end else if (in_hs) begin
      data_d = in_if.data;
      full_d = 1'b1;
      cnt_d  = '0;
    end else if (out_hs && !last) begin
      cnt_d  = cnt_q + 1'b1;
    end else if (out_hs && last) begin
      full_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // State registers, cleared asynchronously so a partial word is dropped at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      full_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_if.valid = full_q;
  assign out_if.last  = last;
  assign out_if.data  = beat;

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer: three instances cover LSB-first 32/4,
// MSB-first 32/4 and LSB-first 24/3.
module tb_stream_downsizer;

  logic clk;
  logic rst_n;
  logic flush_a, flush_b, flush_c;
  int   checks;
  int   errors;

  stream_downsizer_if #(.WIDTH(32)) a_in ();
  stream_downsizer_if #(.WIDTH(8))  a_out ();
  stream_downsizer_if #(.WIDTH(32)) b_in ();
  stream_downsizer_if #(.WIDTH(8))  b_out ();
  stream_downsizer_if #(.WIDTH(24)) c_in ();
  stream_downsizer_if #(.WIDTH(8))  c_out ();

  stream_downsizer #(.DATA_WIDTH_IN(32), .RATIO(4), .LSB_FIRST(1'b1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_a), .in_if(a_in), .out_if(a_out));
  stream_downsizer #(.DATA_WIDTH_IN(32), .RATIO(4), .LSB_FIRST(1'b0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_b), .in_if(b_in), .out_if(b_out));
  stream_downsizer #(.DATA_WIDTH_IN(24), .RATIO(3), .LSB_FIRST(1'b1)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_c), .in_if(c_in), .out_if(c_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_in.last = 1'b0; a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.data = '0; b_in.last = 1'b0; b_out.ready = 1'b1;
    c_in.valid = 1'b0; c_in.data = '0; c_in.last = 1'b0; c_out.ready = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b want 0", a_out.valid); end
    checks++; if (a_out.last !== 1'b0) begin errors++; $display("FAIL reset_last_a got %b want 0", a_out.last); end
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_a got %b want 1", a_in.ready); end
    checks++; if (a_out.data !== 8'h00) begin errors++; $display("FAIL reset_data_a got %h want 00", a_out.data); end
    checks++; if (c_out.valid !== 1'b0) begin errors++; $display("FAIL reset_valid_c got %b want 0", c_out.valid); end
    checks++; if (b_in.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %b want 1", b_in.ready); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", a_out.valid); end
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", a_in.ready); end
    next_cycle();
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4];
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    a_out.ready = 1'b1;
    a_in.valid = 1'b1;
    a_in.data = 32'hDDCCBBAA;
    @(negedge clk);
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", a_in.ready); end
    next_cycle();
    a_in.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_out.valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b want 1", i, a_out.valid); end
      checks++; if (a_out.data !== exp[i]) begin errors++; $display("FAIL single_data beat %0d got %h want %h", i, a_out.data, exp[i]); end
      checks++; if (a_out.last !== (i == 3)) begin errors++; $display("FAIL single_last beat %0d got %b want %b", i, a_out.last, (i == 3)); end
      checks++; if (a_in.ready !== (i == 3)) begin errors++; $display("FAIL single_ready beat %0d got %b want %b", i, a_in.ready, (i == 3)); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", a_out.valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    a_out.ready = 1'b1;
    a_in.valid = 1'b1;
    a_in.data = 32'h03020100;
    next_cycle();
    a_in.data = 32'h07060504;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++; if (a_out.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b want 1", j, a_out.valid); end
      checks++; if (a_out.data !== 8'(j)) begin errors++; $display("FAIL b2b_data beat %0d got %h want %h", j, a_out.data, 8'(j)); end
      checks++; if (a_out.last !== ((j % 4) == 3)) begin errors++; $display("FAIL b2b_last beat %0d got %b want %b", j, a_out.last, ((j % 4) == 3)); end
      checks++; if (a_in.ready !== ((j % 4) == 3)) begin errors++; $display("FAIL b2b_ready beat %0d got %b want %b", j, a_in.ready, ((j % 4) == 3)); end
      next_cycle();
      if (j == 3) a_in.valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", a_out.valid); end
    next_cycle();
  endtask

  task automatic test_msb_first();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    b_out.ready = 1'b1;
    b_in.valid = 1'b1;
    b_in.data = 32'h11223344;
    next_cycle();
    b_in.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (b_out.data !== exp[i]) begin errors++; $display("FAIL msb_data beat %0d got %h want %h", i, b_out.data, exp[i]); end
      checks++; if (b_out.last !== (i == 3)) begin errors++; $display("FAIL msb_last beat %0d got %b want %b", i, b_out.last, (i == 3)); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (b_out.valid !== 1'b0) begin errors++; $display("FAIL msb_drain got %b want 0", b_out.valid); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] q [$];
    logic [31:0] asm_word;
    logic [31:0] exp_word;
    logic [7:0]  pdata;
    logic        plast;
    bit          acc;
    bit          stall;
    int          sent, rcvd, k, cyc;
    sent = 0; rcvd = 0; k = 0; cyc = 0; stall = 1'b0; asm_word = '0;
    pdata = '0; plast = 1'b0;
    a_in.valid = 1'b0;
    while (rcvd < 100 && cyc < 4000) begin
      a_out.ready = 1'($urandom_range(0, 1));
      if (!a_in.valid && sent < 100) begin
        a_in.valid = 1'b1;
        a_in.data = $urandom;
      end
      @(negedge clk);
      if (stall) begin
        checks++;
        if (a_out.valid !== 1'b1 || a_out.data !== pdata || a_out.last !== plast) begin
          errors++;
          $display("FAIL bp_stable got v=%b d=%h l=%b want v=1 d=%h l=%b", a_out.valid, a_out.data, a_out.last, pdata, plast);
        end
      end
      stall = a_out.valid && !a_out.ready;
      pdata = a_out.data;
      plast = a_out.last;
      acc = a_in.valid && a_in.ready;
      if (acc) begin
        q.push_back(a_in.data);
        sent++;
      end
      if (a_out.valid && a_out.ready) begin
        asm_word[k*8 +: 8] = a_out.data;
        checks++; if (a_out.last !== (k == 3)) begin errors++; $display("FAIL bp_last slice %0d got %b want %b", k, a_out.last, (k == 3)); end
        if (k == 3) begin
          k = 0;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL bp_word got %h want none (no word pending)", asm_word);
          end else begin
            exp_word = q.pop_front();
            if (asm_word !== exp_word) begin errors++; $display("FAIL bp_word %0d got %h want %h", rcvd, asm_word, exp_word); end
          end
          rcvd++;
        end else begin
          k++;
        end
      end
      next_cycle();
      cyc++;
      if (acc) a_in.valid = 1'b0;
    end
    checks++; if (rcvd != 100) begin errors++; $display("FAIL bp_timeout got %0d words want 100", rcvd); end
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    next_cycle();
  endtask

  task automatic test_flush();
    logic [7:0] exp [4];
    exp = '{8'h88, 8'h77, 8'h66, 8'h55};
    a_out.ready = 1'b1;
    a_in.valid = 1'b1;
    a_in.data = 32'hA1B2C3D4;
    next_cycle();
    a_in.valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out.data !== 8'hD4) begin errors++; $display("FAIL flush_beat0 got %h want d4", a_out.data); end
    next_cycle();
    @(negedge clk);
    checks++; if (a_out.data !== 8'hC3) begin errors++; $display("FAIL flush_beat1 got %h want c3", a_out.data); end
    next_cycle();
    flush_a = 1'b1;
    a_in.valid = 1'b1;
    a_in.data = 32'h55667788;
    @(negedge clk);
    checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", a_in.ready); end
    next_cycle();
    flush_a = 1'b0;
    @(negedge clk);
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", a_out.valid); end
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b want 1", a_in.ready); end
    next_cycle();
    a_in.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_out.data !== exp[i]) begin errors++; $display("FAIL flush_next beat %0d got %h want %h", i, a_out.data, exp[i]); end
      checks++; if (a_out.last !== (i == 3)) begin errors++; $display("FAIL flush_next_last beat %0d got %b want %b", i, a_out.last, (i == 3)); end
      next_cycle();
    end
  endtask

  task automatic test_ratio3();
    logic       rdy  [5];
    logic [7:0] exp  [5];
    logic       lst  [5];
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC};
    lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    c_out.ready = 1'b1;
    c_in.valid = 1'b1;
    c_in.data = 24'hCCBBAA;
    next_cycle();
    c_in.valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c_out.ready = rdy[i];
      @(negedge clk);
      checks++; if (c_out.valid !== 1'b1) begin errors++; $display("FAIL r3_valid cyc %0d got %b want 1", i, c_out.valid); end
      checks++; if (c_out.data !== exp[i]) begin errors++; $display("FAIL r3_data cyc %0d got %h want %h", i, c_out.data, exp[i]); end
      checks++; if (c_out.last !== lst[i]) begin errors++; $display("FAIL r3_last cyc %0d got %b want %b", i, c_out.last, lst[i]); end
      checks++; if (u_c.cnt_q === 2'd3) begin errors++; $display("FAIL r3_cnt cyc %0d got 3 want <3", i); end
      next_cycle();
    end
    c_out.ready = 1'b1;
    @(negedge clk);
    checks++; if (c_out.valid !== 1'b0) begin errors++; $display("FAIL r3_drain got %b want 0", c_out.valid); end
    next_cycle();
  endtask

  task automatic test_reset_mid_word();
    c_out.ready = 1'b1;
    c_in.valid = 1'b1;
    c_in.data = 24'h332211;
    next_cycle();
    c_in.valid = 1'b0;
    @(negedge clk);
    checks++; if (c_out.data !== 8'h11) begin errors++; $display("FAIL rstmid_beat0 got %h want 11", c_out.data); end
    next_cycle();
    c_out.ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (c_out.valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", c_out.valid); end
    checks++; if (c_out.last !== 1'b0) begin errors++; $display("FAIL rstmid_last got %b want 0", c_out.last); end
    checks++; if (c_out.data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", c_out.data); end
    checks++; if (c_in.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", c_in.ready); end
    next_cycle();
    rst_n = 1'b1;
    c_out.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (c_out.valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cyc %0d got %b want 0", i, c_out.valid); end
      next_cycle();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_msb_first();
    test_backpressure();
    test_flush();
    test_ratio3();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
